bresenham_ray_walker: RTL and testbench

//  Sequential, all-octant integer Bresenham line walker for the occupancy-grid update path.

---
 rtl/bresenham_pkg.sv | 8 +
 rtl/ram_pkg.sv | 7 +
 rtl/bresenham_ray_walker_if.sv | 13 +
 rtl/bresenham_setup.sv | 28 ++
 rtl/bresenham_ray_walker.sv | 76 +++++++
 tb/tb_bresenham_ray_walker.sv | 236 +++++++++++++++++++++++
 6 files changed

// File: rtl/bresenham_pkg.sv
// bresenham_pkg: error/step types and walker states for the ray walker
package bresenham_pkg;
  localparam int ERR_W = (ram_pkg::WIDTH_INDEX_WIDTH > ram_pkg::HEIGHT_INDEX_WIDTH ?
                          ram_pkg::WIDTH_INDEX_WIDTH : ram_pkg::HEIGHT_INDEX_WIDTH) + 2;
  typedef logic signed [ERR_W-1:0] err_t;
  typedef logic signed [1:0] step_t;
  typedef enum logic [1:0] {IDLE, SETUP, WALK} walker_state_t;
endpackage

// File: rtl/ram_pkg.sv
// ram_pkg: occupancy-grid index widths and types shared by the map RAM path
package ram_pkg;
  localparam int WIDTH_INDEX_WIDTH = 5;
  localparam int HEIGHT_INDEX_WIDTH = 4;
  typedef logic [WIDTH_INDEX_WIDTH-1:0] width_index_t;
  typedef logic [HEIGHT_INDEX_WIDTH-1:0] height_index_t;
endpackage

// File: rtl/bresenham_ray_walker_if.sv
// bresenham_ray_walker_if: ray request and cell stream handshakes
interface bresenham_ray_walker_if #(
  parameter int X_W = ram_pkg::WIDTH_INDEX_WIDTH,
  parameter int Y_W = ram_pkg::HEIGHT_INDEX_WIDTH
);
  logic ray_valid, ray_ready, cell_valid, cell_ready, cell_last, busy;
  logic [X_W-1:0] start_x, end_x, cell_x;
  logic [Y_W-1:0] start_y, end_y, cell_y;
  modport master(output ray_valid, start_x, start_y, end_x, end_y, cell_ready,
                 input ray_ready, cell_valid, cell_x, cell_y, cell_last, busy);
  modport slave(input ray_valid, start_x, start_y, end_x, end_y, cell_ready,
                output ray_ready, cell_valid, cell_x, cell_y, cell_last, busy);
endinterface

// File: rtl/bresenham_setup.sv
// bresenham_setup: per-ray deltas, step directions and initial error
module bresenham_setup
  import bresenham_pkg::*;
#(
  parameter int X_W = ram_pkg::WIDTH_INDEX_WIDTH,
  parameter int Y_W = ram_pkg::HEIGHT_INDEX_WIDTH
) (
  input  logic [X_W-1:0] start_x,
  input  logic [Y_W-1:0] start_y,
  input  logic [X_W-1:0] end_x,
  input  logic [Y_W-1:0] end_y,
  output err_t           dx,
  output err_t           dy,
  output err_t           err0,
  output step_t          sx,
  output step_t          sy
);
  err_t x0, x1, y0, y1;
  assign x0 = err_t'(start_x);
  assign x1 = err_t'(end_x);
  assign y0 = err_t'(start_y);
  assign y1 = err_t'(end_y);
  assign dx = end_x > start_x ? x1 - x0 : x0 - x1;
  assign dy = end_y > start_y ? y0 - y1 : y1 - y0;
  assign sx = end_x > start_x ? 2'sb01 : 2'sb11;
  assign sy = end_y > start_y ? 2'sb01 : 2'sb11;
  assign err0 = dx + dy;
endmodule

// File: rtl/bresenham_ray_walker.sv
// bresenham_ray_walker: all-octant Bresenham walker streaming one cell per beat
module bresenham_ray_walker
  import bresenham_pkg::*;
#(
  parameter int X_W = ram_pkg::WIDTH_INDEX_WIDTH,
  parameter int Y_W = ram_pkg::HEIGHT_INDEX_WIDTH,
  parameter bit EMIT_ENDPOINT = 1'b1
) (
  input logic clock,
  input logic reset,
  bresenham_ray_walker_if.slave rw
);
  walker_state_t state, state_n;
  logic [X_W-1:0] st_x, en_x, cur_x, nx;
  logic [Y_W-1:0] st_y, en_y, cur_y, ny;
  err_t dx, dy, err0, dx_r, dy_r, err, err_n;
  step_t sx, sy, sx_r, sy_r;
  logic signed [ERR_W:0] e2, dxw, dyw;
  logic step_x, step_y, fire, last, degenerate;
  bresenham_setup #(.X_W(X_W), .Y_W(Y_W)) u_setup (
    .start_x(st_x), .start_y(st_y), .end_x(en_x), .end_y(en_y),
    .dx(dx), .dy(dy), .err0(err0), .sx(sx), .sy(sy)
  );
  assign e2 = {err, 1'b0};
  assign dxw = {dx_r[ERR_W-1], dx_r};
  assign dyw = {dy_r[ERR_W-1], dy_r};
  assign step_x = e2 >= dyw;
  assign step_y = e2 <= dxw;
  assign nx = step_x ? cur_x + X_W'(sx_r) : cur_x;
  assign ny = step_y ? cur_y + Y_W'(sy_r) : cur_y;
  assign err_n = err + (step_x ? dy_r : err_t'(0)) + (step_y ? dx_r : err_t'(0));
  // Without the endpoint, the final beat is the one whose successor would be the endpoint
  assign last = EMIT_ENDPOINT ? (cur_x == en_x && cur_y == en_y) : (nx == en_x && ny == en_y);
  assign degenerate = st_x == en_x && st_y == en_y;
  assign fire = state == WALK && rw.cell_ready;
  always_comb begin
    state_n = state == IDLE  ? (rw.ray_valid ? SETUP : IDLE) :
              state == SETUP ? (!EMIT_ENDPOINT && degenerate ? IDLE : WALK) :
                               (fire && last ? IDLE : WALK);
  end
  assign rw.ray_ready = state == IDLE;
  assign rw.busy = state != IDLE;
  assign rw.cell_valid = state == WALK;
  assign rw.cell_last = state == WALK && last;
  assign rw.cell_x = cur_x;
  assign rw.cell_y = cur_y;
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      {st_x, st_y, en_x, en_y, cur_x, cur_y} <= '0;
      {dx_r, dy_r, err, sx_r, sy_r} <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && rw.ray_valid) begin
        st_x <= rw.start_x;
        st_y <= rw.start_y;
        en_x <= rw.end_x;
        en_y <= rw.end_y;
      end
      if (state == SETUP) begin
        cur_x <= st_x;
        cur_y <= st_y;
        err <= err0;
        dx_r <= dx;
        dy_r <= dy;
        sx_r <= sx;
        sy_r <= sy;
      end
      if (fire && !last) begin
        cur_x <= nx;
        cur_y <= ny;
        err <= err_n;
      end
    end
  end
endmodule

// File: tb/tb_bresenham_ray_walker.sv
// tb_bresenham_ray_walker: directed and randomized checks of the ray walker
module tb_bresenham_ray_walker;
  import ram_pkg::*;
  localparam int XW = WIDTH_INDEX_WIDTH;
  localparam int YW = HEIGHT_INDEX_WIDTH;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;
  bresenham_ray_walker_if #(.X_W(XW), .Y_W(YW)) rw();
  bresenham_ray_walker_if #(.X_W(XW), .Y_W(YW)) rw0();
  bresenham_ray_walker #(.X_W(XW), .Y_W(YW), .EMIT_ENDPOINT(1'b1)) dut (
    .clock(clock), .reset(reset), .rw(rw)
  );
  bresenham_ray_walker #(.X_W(XW), .Y_W(YW), .EMIT_ENDPOINT(1'b0)) dut0 (
    .clock(clock), .reset(reset), .rw(rw0)
  );
  int checks = 0;
  int fails = 0;
  int gx[$], gy[$], mx[$], my[$];
  bit glast[$];
  bit rr_seen;
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic send(input int x0, input int y0, input int x1, input int y1);
    rw.start_x = XW'(x0);
    rw.start_y = YW'(y0);
    rw.end_x = XW'(x1);
    rw.end_y = YW'(y1);
    rw.ray_valid = 1'b1;
    for (int i = 0; i < 200 && !rw.ray_ready; i++) tick();
    tick();
    rw.ray_valid = 1'b0;
  endtask
  task automatic collect(input bit rnd, output bit ok);
    bit done = 1'b0;
    gx.delete(); gy.delete(); glast.delete();
    rr_seen = 1'b0;
    for (int c = 0; c < 400 && !done; c++) begin
      rw.cell_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (rnd) begin
        rw.ray_valid = 1'($urandom_range(0, 1));
        rw.start_x = XW'($urandom);
        rw.start_y = YW'($urandom);
        rw.end_x = XW'($urandom);
        rw.end_y = YW'($urandom);
      end
      if (rw.cell_valid && rw.ray_ready) rr_seen = 1'b1;
      if (rw.cell_valid && rw.cell_ready) begin
        gx.push_back(int'(rw.cell_x));
        gy.push_back(int'(rw.cell_y));
        glast.push_back(rw.cell_last);
        if (rw.cell_last) begin
          done = 1'b1;
          rw.ray_valid = 1'b0;
        end
      end
      tick();
    end
    rw.ray_valid = 1'b0;
    rw.cell_ready = 1'b1;
    ok = done;
  endtask
  function automatic void model(input int x0, input int y0, input int x1, input int y1, input bit emit);
    int dx, dy, sx, sy, err, e2, x, y;
    mx.delete(); my.delete();
    dx = x1 > x0 ? x1 - x0 : x0 - x1;
    dy = y1 > y0 ? y0 - y1 : y1 - y0;
    sx = x1 > x0 ? 1 : -1;
    sy = y1 > y0 ? 1 : -1;
    err = dx + dy;
    x = x0;
    y = y0;
    for (int i = 0; i < 200; i++) begin
      if (x == x1 && y == y1) begin
        if (emit) begin mx.push_back(x); my.push_back(y); end
        break;
      end
      mx.push_back(x); my.push_back(y);
      e2 = 2 * err;
      if (e2 >= dy) begin err += dy; x += sx; end
      if (e2 <= dx) begin err += dx; y += sy; end
    end
  endfunction
  task automatic test_reset();
    rw.ray_valid = 0; rw.cell_ready = 1; rw.start_x = 0; rw.start_y = 0; rw.end_x = 0; rw.end_y = 0;
    rw0.ray_valid = 0; rw0.cell_ready = 1; rw0.start_x = 0; rw0.start_y = 0; rw0.end_x = 0; rw0.end_y = 0;
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    checks++; if (rw.ray_ready !== 1'b1) begin fails++; $display("FAIL rst_ray_ready: got %b want 1", rw.ray_ready); end
    checks++; if (rw.cell_valid !== 1'b0) begin fails++; $display("FAIL rst_cell_valid: got %b want 0", rw.cell_valid); end
    checks++; if (rw.cell_last !== 1'b0) begin fails++; $display("FAIL rst_cell_last: got %b want 0", rw.cell_last); end
    checks++; if (rw.busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b want 0", rw.busy); end
    checks++; if (rw.cell_x !== '0 || rw.cell_y !== '0) begin fails++; $display("FAIL rst_cell_xy: got (%0d,%0d) want (0,0)", rw.cell_x, rw.cell_y); end
    checks++; if (rw0.ray_ready !== 1'b1 || rw0.cell_valid !== 1'b0 || rw0.busy !== 1'b0) begin fails++; $display("FAIL rst_emit0: got ready=%b valid=%b busy=%b want 1 0 0", rw0.ray_ready, rw0.cell_valid, rw0.busy); end
  endtask
  task automatic test_horizontal();
    int ex[] = '{2, 3, 4, 5, 6};
    bit ok;
    rw.start_x = 2; rw.start_y = 3; rw.end_x = 6; rw.end_y = 3;
    rw.ray_valid = 1'b1;
    tick();
    rw.ray_valid = 1'b0;
    checks++; if (rw.cell_valid !== 1'b0 || rw.busy !== 1'b1 || rw.ray_ready !== 1'b0) begin fails++; $display("FAIL h_setup: got valid=%b busy=%b ready=%b want 0 1 0", rw.cell_valid, rw.busy, rw.ray_ready); end
    tick();
    checks++; if (rw.cell_valid !== 1'b1 || rw.cell_x !== 5'd2 || rw.cell_y !== 4'd3) begin fails++; $display("FAIL h_first_beat: got valid=%b (%0d,%0d) want 1 (2,3)", rw.cell_valid, rw.cell_x, rw.cell_y); end
    collect(1'b0, ok);
    checks++; if (!ok || gx.size() != 5) begin fails++; $display("FAIL h_count: got %0d beats (done=%b) want 5", gx.size(), ok); end
    for (int i = 0; i < 5 && i < gx.size(); i++) begin
      checks++;
      if (gx[i] != ex[i] || gy[i] != 3 || glast[i] != (i == 4)) begin fails++; $display("FAIL h_beat%0d: got (%0d,%0d) last=%b want (%0d,3) last=%b", i, gx[i], gy[i], glast[i], ex[i], i == 4); end
    end
    checks++; if (rw.ray_ready !== 1'b1 || rw.busy !== 1'b0) begin fails++; $display("FAIL h_idle: got ready=%b busy=%b want 1 0", rw.ray_ready, rw.busy); end
  endtask
  task automatic test_steep();
    int ex[] = '{5, 5, 4, 4, 3, 3};
    int ey[] = '{5, 4, 3, 2, 1, 0};
    bit ok;
    send(5, 5, 3, 0);
    collect(1'b0, ok);
    checks++; if (!ok || gx.size() != 6) begin fails++; $display("FAIL s_count: got %0d beats want 6", gx.size()); end
    for (int i = 0; i < 6 && i < gx.size(); i++) begin
      checks++;
      if (gx[i] != ex[i] || gy[i] != ey[i] || glast[i] != (i == 5)) begin fails++; $display("FAIL s_beat%0d: got (%0d,%0d) last=%b want (%0d,%0d)", i, gx[i], gy[i], glast[i], ex[i], ey[i]); end
    end
  endtask
  task automatic test_degenerate();
    int qx[$];
    bit ok, last_ok;
    send(7, 7, 7, 7);
    collect(1'b0, ok);
    checks++; if (!ok || gx.size() != 1 || gx[0] != 7 || gy[0] != 7 || !glast[0]) begin fails++; $display("FAIL d_emit1: got %0d beats want 1 beat (7,7) last", gx.size()); end
    rw0.start_x = 7; rw0.start_y = 7; rw0.end_x = 7; rw0.end_y = 7;
    rw0.ray_valid = 1'b1;
    tick();
    rw0.ray_valid = 1'b0;
    checks++; if (rw0.busy !== 1'b1 || rw0.cell_valid !== 1'b0) begin fails++; $display("FAIL d_setup: got busy=%b valid=%b want 1 0", rw0.busy, rw0.cell_valid); end
    tick();
    checks++; if (rw0.ray_ready !== 1'b1 || rw0.busy !== 1'b0 || rw0.cell_valid !== 1'b0) begin fails++; $display("FAIL d_emit0_idle: got ready=%b busy=%b valid=%b want 1 0 0", rw0.ray_ready, rw0.busy, rw0.cell_valid); end
    rw0.start_x = 2; rw0.start_y = 3; rw0.end_x = 6; rw0.end_y = 3;
    rw0.ray_valid = 1'b1;
    tick();
    rw0.ray_valid = 1'b0;
    last_ok = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (rw0.cell_valid) begin
        qx.push_back(int'(rw0.cell_x));
        checks++;
        if (rw0.cell_y !== 4'd3 || rw0.cell_last !== (rw0.cell_x == 5'd5)) begin fails++; $display("FAIL e0_beat: got (%0d,%0d) last=%b", rw0.cell_x, rw0.cell_y, rw0.cell_last); end
        if (rw0.cell_last) begin last_ok = 1'b1; tick(); break; end
      end
      tick();
    end
    checks++; if (!last_ok || qx.size() != 4 || qx[0] != 2 || qx[3] != 5) begin fails++; $display("FAIL e0_count: got %0d beats want 4 (x=2..5)", qx.size()); end
  endtask
  task automatic test_stall();
    int ex[] = '{0, 1, 2, 3};
    int stall = 0;
    bit done = 1'b0;
    send(0, 0, 3, 3);
    gx.delete(); gy.delete(); glast.delete();
    for (int c = 0; c < 40 && !done; c++) begin
      rw.cell_ready = !(rw.cell_valid && gx.size() == 1 && stall < 3);
      if (!rw.cell_ready) begin
        stall++;
        checks++;
        if (rw.cell_x !== 5'd1 || rw.cell_y !== 4'd1 || rw.cell_valid !== 1'b1 || rw.cell_last !== 1'b0) begin fails++; $display("FAIL st_hold%0d: got valid=%b (%0d,%0d) last=%b want 1 (1,1) 0", stall, rw.cell_valid, rw.cell_x, rw.cell_y, rw.cell_last); end
      end
      if (rw.cell_valid && rw.cell_ready) begin
        gx.push_back(int'(rw.cell_x)); gy.push_back(int'(rw.cell_y)); glast.push_back(rw.cell_last);
        done = rw.cell_last;
      end
      tick();
    end
    rw.cell_ready = 1'b1;
    checks++; if (!done || gx.size() != 4 || stall != 3) begin fails++; $display("FAIL st_count: got %0d beats stall=%0d want 4 beats stall=3", gx.size(), stall); end
    for (int i = 0; i < 4 && i < gx.size(); i++) begin
      checks++;
      if (gx[i] != ex[i] || gy[i] != ex[i]) begin fails++; $display("FAIL st_beat%0d: got (%0d,%0d) want (%0d,%0d)", i, gx[i], gy[i], ex[i], ex[i]); end
    end
  endtask
  task automatic test_reset_mid();
    int nb = 0;
    bit hit = 1'b0;
    bit ok;
    send(0, 0, 10, 4);
    for (int c = 0; c < 40; c++) begin
      if (rw.cell_valid) begin
        if (nb == 2) begin hit = 1'b1; break; end
        nb++;
      end
      tick();
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (!hit) begin fails++; $display("FAIL rm_third_beat: got %0d beats want 3rd beat reached", nb); end
    checks++; if (rw.cell_valid !== 1'b0 || rw.ray_ready !== 1'b1 || rw.busy !== 1'b0) begin fails++; $display("FAIL rm_abort: got valid=%b ready=%b busy=%b want 0 1 0", rw.cell_valid, rw.ray_ready, rw.busy); end
    tick();
    checks++; if (rw.cell_valid !== 1'b0) begin fails++; $display("FAIL rm_no_beats: got valid=%b want 0", rw.cell_valid); end
    send(2, 1, 5, 2);
    collect(1'b0, ok);
    model(2, 1, 5, 2, 1'b1);
    checks++; if (!ok || gx != mx || gy != my) begin fails++; $display("FAIL rm_new_ray: got %0d beats want %0d", gx.size(), mx.size()); end
  endtask
  task automatic test_random();
    int x0, y0, x1, y1;
    bit ok;
    for (int r = 0; r < 1000; r++) begin
      x0 = $urandom_range(0, (1 << XW) - 1); x1 = $urandom_range(0, (1 << XW) - 1);
      y0 = $urandom_range(0, (1 << YW) - 1); y1 = $urandom_range(0, (1 << YW) - 1);
      send(x0, y0, x1, y1);
      model(x0, y0, x1, y1, 1'b1);
      collect(1'b1, ok);
      checks++;
      if (!ok || gx != mx || gy != my || rr_seen) begin
        fails++;
        $display("FAIL rnd%0d (%0d,%0d)->(%0d,%0d): got %0d beats done=%b ready_while_busy=%b want %0d beats", r, x0, y0, x1, y1, gx.size(), ok, rr_seen, mx.size());
      end
    end
  endtask
  initial begin
    test_reset();
    test_horizontal();
    test_steep();
    test_degenerate();
    test_stall();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
